pseudo_spi_rx_intf: RTL and testbench

Receive-side counterpart of the pseudo-SPI output interface. Given a start address and word count, it raises SEL so the analog device loads its read-back chain, generates the two-phase SCLK1/SCLK2 pulses, shifts SPI_SI in LSB-first, and writes each assembled word into SRAM at descending addresses. It sits between the CPU's SRAM port and the analog device, using the same bit timing as the transmit path.

---
 rtl/pseudo_spi_rx_intf_pkg.sv | 30 +++
 rtl/pseudo_spi_rx_intf_if.sv | 34 +++
 rtl/pseudo_spi_rx_intf_bit_timer.sv | 54 +++++
 rtl/pseudo_spi_rx_intf.sv | 129 ++++++++++++
 tb/tb_pseudo_spi_rx_intf.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pseudo_spi_rx_intf_pkg.sv
// Shared constants for the pseudo-SPI receive path: widths, FSM encodings,
// bit-period timing (same phase values as the transmit path) and the
// SRAM write payload type.
package pseudo_spi_rx_intf_pkg;

  localparam int unsigned MEMORY_DATA_WIDTH = 8;
  localparam int unsigned MEMORY_ADDR_WIDTH = 9;
  localparam int unsigned RESERVED_DATA_LEN = 8;

  localparam int unsigned BIT_PERIOD = 5;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned BCNT_W     = $clog2(MEMORY_DATA_WIDTH);
  localparam int unsigned STATE_W    = 3;

  localparam logic [PHASE_W-1:0] PHASE_TOP   = PHASE_W'(BIT_PERIOD - 1);
  localparam logic [PHASE_W-1:0] SCLK1_PHASE = 3'd3;
  localparam logic [PHASE_W-1:0] SCLK2_PHASE = 3'd1;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] ST_SHIFT = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [MEMORY_ADDR_WIDTH-1:0] addr;
    logic [MEMORY_DATA_WIDTH-1:0] data;
  } sram_wr_t;

endpackage

// File: rtl/pseudo_spi_rx_intf_if.sv
// Bus bundle between the receive interface, the CPU SRAM port and the
// analog device. master = the receive block, slave = its environment.
//   BGN/ADDR_BGN/DATA_LEN : transfer request
//   SPI_SI                : serial data from device
//   SCLK1/SCLK2/SEL       : device shift clocks and read-select
//   A/PO/CEN/D_WE         : SRAM write port (active-low enables)
//   spi_is_done           : transfer complete
interface pseudo_spi_rx_intf_if;
  import pseudo_spi_rx_intf_pkg::*;

  logic                         BGN;
  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
  logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
  logic                         SPI_SI;
  logic                         SCLK1;
  logic                         SCLK2;
  logic                         SEL;
  logic [MEMORY_ADDR_WIDTH-1:0] A;
  logic [MEMORY_DATA_WIDTH-1:0] PO;
  logic                         CEN;
  logic                         D_WE;
  logic                         spi_is_done;

  modport master (
    input  BGN, ADDR_BGN, DATA_LEN, SPI_SI,
    output SCLK1, SCLK2, SEL, A, PO, CEN, D_WE, spi_is_done
  );

  modport slave (
    output BGN, ADDR_BGN, DATA_LEN, SPI_SI,
    input  SCLK1, SCLK2, SEL, A, PO, CEN, D_WE, spi_is_done
  );

endinterface

// File: rtl/pseudo_spi_rx_intf_bit_timer.sv
// Bit-period phase counter (runs PHASE_TOP..0) with registered SCLK1/SCLK2
// decode and the combinational sample strike at phase 0.
//   i_load      : preset phase to PHASE_TOP on the next edge
//   i_en        : count down (wraps to PHASE_TOP after 0); holds otherwise
//   i_shift_nxt : FSM enters/stays in SHIFT next cycle, enables SCLK pulses
//   o_strike_c  : last cycle of the current period
//   o_sclk1/2   : registered shift clocks
module pseudo_spi_bit_timer
  import pseudo_spi_rx_intf_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic i_load,
  input  logic i_en,
  input  logic i_shift_nxt,
  output logic o_strike_c,
  output logic o_sclk1,
  output logic o_sclk2
);

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic               r_sclk1;
  logic               r_sclk2;

  // Next phase; held while disabled so WRITE leaves the next period at its top.
  always_comb begin
    w_phase_nxt = r_phase;
    if (i_load) begin
      w_phase_nxt = PHASE_TOP;
    end else if (i_en) begin
      w_phase_nxt = (r_phase == '0) ? PHASE_TOP : r_phase - PHASE_W'(1);
    end
  end

  assign o_strike_c = i_en && !i_load && (r_phase == '0);

  // Clocks are registered from the next phase so they align with that phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_phase <= '0;
      r_sclk1 <= 1'b0;
      r_sclk2 <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_sclk1 <= i_shift_nxt && (w_phase_nxt == SCLK1_PHASE);
      r_sclk2 <= i_shift_nxt && (w_phase_nxt == SCLK2_PHASE);
    end
  end

  assign o_sclk1 = r_sclk1;
  assign o_sclk2 = r_sclk2;

endmodule

// File: rtl/pseudo_spi_rx_intf.sv
// Pseudo-SPI receive interface: raises SEL to load the device read-back
// chain, clocks DATA_LEN+1 words in LSB-first on SPI_SI, and writes each
// word to SRAM at descending addresses starting at ADDR_BGN.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : master side of pseudo_spi_rx_intf_if
module pseudo_spi_rx_intf
  import pseudo_spi_rx_intf_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  pseudo_spi_rx_intf_if.master bus
);

  logic [STATE_W-1:0]           r_state, w_state_nxt;
  logic [MEMORY_ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
  logic [RESERVED_DATA_LEN-1:0] r_wcnt,  w_wcnt_nxt;
  logic [BCNT_W-1:0]            r_bcnt,  w_bcnt_nxt;
  logic [MEMORY_DATA_WIDTH-1:0] r_shreg, w_shreg_nxt;
  sram_wr_t                     r_wr,    w_wr_nxt;
  logic                         r_sel, r_cen, r_dwe, r_done;
  logic                         w_strike, w_sclk1, w_sclk2;

  pseudo_spi_bit_timer u_bit_timer (
    .CLK         (CLK),
    .RST         (RST),
    .i_load      (r_state == ST_IDLE),
    .i_en        ((r_state == ST_LOAD) || (r_state == ST_SHIFT)),
    .i_shift_nxt (w_state_nxt == ST_SHIFT),
    .o_strike_c  (w_strike),
    .o_sclk1     (w_sclk1),
    .o_sclk2     (w_sclk2)
  );

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wcnt_nxt  = r_wcnt;
    w_bcnt_nxt  = r_bcnt;
    w_shreg_nxt = r_shreg;
    w_wr_nxt    = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.BGN) begin
          w_state_nxt = ST_LOAD;
          w_addr_nxt  = bus.ADDR_BGN;
          w_wcnt_nxt  = bus.DATA_LEN;
          w_shreg_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (w_strike) begin
          w_state_nxt = ST_SHIFT;
          w_bcnt_nxt  = BCNT_W'(MEMORY_DATA_WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        if (w_strike) begin
          w_shreg_nxt = {bus.SPI_SI, r_shreg[MEMORY_DATA_WIDTH-1:1]};
          if (r_bcnt != '0) begin
            w_bcnt_nxt = r_bcnt - BCNT_W'(1);
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (r_wcnt != '0) begin
          w_state_nxt = ST_SHIFT;
          w_wcnt_nxt  = r_wcnt - RESERVED_DATA_LEN'(1);
          w_addr_nxt  = r_addr - MEMORY_ADDR_WIDTH'(1);
          w_bcnt_nxt  = BCNT_W'(MEMORY_DATA_WIDTH - 1);
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.BGN) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // SRAM drive is zero outside WRITE.
    if (w_state_nxt == ST_WRITE) begin
      w_wr_nxt.addr = w_addr_nxt;
      w_wr_nxt.data = w_shreg_nxt;
    end
  end

  // State, datapath and output registers; outputs follow the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
      r_shreg <= '0;
      r_wr    <= '0;
      r_sel   <= 1'b0;
      r_cen   <= 1'b1;
      r_dwe   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_wr    <= w_wr_nxt;
      r_sel   <= (w_state_nxt == ST_LOAD);
      r_cen   <= (w_state_nxt != ST_WRITE);
      r_dwe   <= (w_state_nxt != ST_WRITE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.SCLK1       = w_sclk1;
  assign bus.SCLK2       = w_sclk2;
  assign bus.SEL         = r_sel;
  assign bus.A           = r_wr.addr;
  assign bus.PO          = r_wr.data;
  assign bus.CEN         = r_cen;
  assign bus.D_WE        = r_dwe;
  assign bus.spi_is_done = r_done;

endmodule

// File: tb/tb_pseudo_spi_rx_intf.sv
// Directed bench for pseudo_spi_rx_intf: a device model serves SPI_SI
// LSB-first on each SCLK1 pulse; a negedge monitor counts clocks/SEL and
// captures SRAM writes.
module tb_pseudo_spi_rx_intf;
  import pseudo_spi_rx_intf_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  bit   tb_si;

  always #5 CLK = ~CLK;

  pseudo_spi_rx_intf_if bus ();

  pseudo_spi_rx_intf dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.SPI_SI = tb_si;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Device model and monitor
  logic [7:0] tx_words [0:7];
  int         tx_base = 0;
  int         k;
  int         sclk1_cnt = 0, sclk2_cnt = 0, sel_rise = 0, sel_cyc = 0;
  int         overlap_cnt = 0, wr_sclk_cnt = 0, wr_cnt = 0;
  bit         sel_d;
  sram_wr_t   wr_a [0:63];

  always @(negedge CLK) begin
    if (bus.SCLK1 === 1'b1) begin
      k     = sclk1_cnt - tx_base;
      tb_si = tx_words[(k / 8) % 8][k % 8];
      sclk1_cnt++;
    end
    if (bus.SCLK2 === 1'b1) sclk2_cnt++;
    if (bus.SCLK1 === 1'b1 && bus.SCLK2 === 1'b1) overlap_cnt++;
    if (bus.CEN === 1'b0 && (bus.SCLK1 === 1'b1 || bus.SCLK2 === 1'b1)) wr_sclk_cnt++;
    if (bus.SEL === 1'b1) sel_cyc++;
    if (bus.SEL === 1'b1 && !sel_d) sel_rise++;
    sel_d = (bus.SEL === 1'b1);
    if (bus.CEN === 1'b0 && bus.D_WE === 1'b0 && wr_cnt < 64) begin
      wr_a[wr_cnt].addr = bus.A;
      wr_a[wr_cnt].data = bus.PO;
      wr_cnt++;
    end
  end

  task automatic start_xfer(input logic [8:0] a, input logic [7:0] len);
    @(negedge CLK);
    bus.ADDR_BGN = a;
    bus.DATA_LEN = len;
    tx_base      = sclk1_cnt;
    bus.BGN      = 1'b1;
  endtask

  // Edges from the BGN-sampling edge until spi_is_done is seen.
  task automatic wait_done(input bit toggle, output int n);
    n = 0;
    @(posedge CLK);
    while (n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
      if (toggle && n == 20) bus.BGN = 1'b0;
      if (toggle && n == 23) bus.BGN = 1'b1;
      if (bus.spi_is_done === 1'b1) break;
    end
  endtask

  // BGN held high keeps DONE; dropping it clears spi_is_done next cycle.
  task automatic release_done(input string tag);
    repeat (3) @(posedge CLK);
    #1;
    check_eq({tag, "_done_hold"}, 32'(bus.spi_is_done), 32'd1);
    @(negedge CLK);
    bus.BGN = 1'b0;
    @(posedge CLK);
    #1;
    check_eq({tag, "_done_clear"}, 32'(bus.spi_is_done), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_sclk1"}, 32'(bus.SCLK1), 32'd0);
    check_eq({tag, "_sclk2"}, 32'(bus.SCLK2), 32'd0);
    check_eq({tag, "_sel"},   32'(bus.SEL),   32'd0);
    check_eq({tag, "_cen"},   32'(bus.CEN),   32'd1);
    check_eq({tag, "_dwe"},   32'(bus.D_WE),  32'd1);
    check_eq({tag, "_a"},     32'(bus.A),     32'd0);
    check_eq({tag, "_po"},    32'(bus.PO),    32'd0);
    check_eq({tag, "_done"},  32'(bus.spi_is_done), 32'd0);
  endtask

  int n, b, s1, s2, sr, sc, guard;

  initial begin
    RST          = 1'b1;
    bus.BGN      = 1'b0;
    bus.ADDR_BGN = '0;
    bus.DATA_LEN = '0;
    for (int i = 0; i < 8; i++) tx_words[i] = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check_idle_outputs("rst");
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    // Single word
    tx_words[0] = 8'hA5;
    b = wr_cnt; s1 = sclk1_cnt; s2 = sclk2_cnt; sr = sel_rise; sc = sel_cyc;
    start_xfer(9'h010, 8'd0);
    wait_done(1'b0, n);
    check_eq("t1_latency", 32'(n), 32'd46);
    release_done("t1");
    check_eq("t1_nwr",   32'(wr_cnt - b), 32'd1);
    check_eq("t1_addr",  32'(wr_a[b].addr), 32'h010);
    check_eq("t1_data",  32'(wr_a[b].data), 32'hA5);
    check_eq("t1_sclk1", 32'(sclk1_cnt - s1), 32'd8);
    check_eq("t1_sclk2", 32'(sclk2_cnt - s2), 32'd8);
    check_eq("t1_selcyc", 32'(sel_cyc - sc), 32'd5);
    check_eq("t1_selrise", 32'(sel_rise - sr), 32'd1);

    // Multi-word with BGN toggled during SHIFT
    tx_words[0] = 8'h3C; tx_words[1] = 8'hFF; tx_words[2] = 8'h01;
    b = wr_cnt; s1 = sclk1_cnt; sr = sel_rise; sc = sel_cyc;
    start_xfer(9'h105, 8'd2);
    wait_done(1'b1, n);
    check_eq("t2_latency", 32'(n), 32'd128);
    release_done("t2");
    check_eq("t2_nwr",   32'(wr_cnt - b), 32'd3);
    check_eq("t2_a0",    32'(wr_a[b].addr),   32'h105);
    check_eq("t2_d0",    32'(wr_a[b].data),   32'h3C);
    check_eq("t2_a1",    32'(wr_a[b+1].addr), 32'h104);
    check_eq("t2_d1",    32'(wr_a[b+1].data), 32'hFF);
    check_eq("t2_a2",    32'(wr_a[b+2].addr), 32'h103);
    check_eq("t2_d2",    32'(wr_a[b+2].data), 32'h01);
    check_eq("t2_sclk1", 32'(sclk1_cnt - s1), 32'd24);
    check_eq("t2_selrise", 32'(sel_rise - sr), 32'd1);
    check_eq("t2_selcyc", 32'(sel_cyc - sc), 32'd5);

    // Address wrap
    tx_words[0] = 8'h5A; tx_words[1] = 8'hC3;
    b = wr_cnt;
    start_xfer(9'h000, 8'd1);
    wait_done(1'b0, n);
    check_eq("t3_latency", 32'(n), 32'd87);
    release_done("t3");
    check_eq("t3_nwr", 32'(wr_cnt - b), 32'd2);
    check_eq("t3_a0",  32'(wr_a[b].addr),   32'h000);
    check_eq("t3_d0",  32'(wr_a[b].data),   32'h5A);
    check_eq("t3_a1",  32'(wr_a[b+1].addr), 32'h1FF);
    check_eq("t3_d1",  32'(wr_a[b+1].data), 32'hC3);

    // Reset in the middle of word 2
    tx_words[0] = 8'h11; tx_words[1] = 8'h22;
    b = wr_cnt;
    start_xfer(9'h020, 8'd1);
    guard = 0;
    while ((wr_cnt - b) < 1 && guard < 200) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    check_eq("t4_first_wr", 32'(wr_cnt - b), 32'd1);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RST     = 1'b1;
    bus.BGN = 1'b0;
    @(posedge CLK);
    #1;
    check_idle_outputs("t4_rst");
    @(negedge CLK);
    RST = 1'b0;
    repeat (60) @(posedge CLK);
    #1;
    check_eq("t4_nwr",  32'(wr_cnt - b), 32'd1);
    check_eq("t4_a0",   32'(wr_a[b].addr), 32'h020);
    check_eq("t4_d0",   32'(wr_a[b].data), 32'h11);

    // Clean restart after reset
    tx_words[0] = 8'h77;
    b = wr_cnt;
    start_xfer(9'h030, 8'd0);
    wait_done(1'b0, n);
    check_eq("t5_latency", 32'(n), 32'd46);
    release_done("t5");
    check_eq("t5_nwr",  32'(wr_cnt - b), 32'd1);
    check_eq("t5_addr", 32'(wr_a[b].addr), 32'h030);
    check_eq("t5_data", 32'(wr_a[b].data), 32'h77);

    check_eq("sclk_overlap", 32'(overlap_cnt), 32'd0);
    check_eq("sclk_in_write", 32'(wr_sclk_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
